uvmt_cv32e40x_rvfi_csr_shadow: RTL and testbench

Downstream consumer of one per-CSR RVFI channel (rmask/wmask/rdata/wdata), instantiated once per tracked CSR next to the formal CSR interface binds in cv32e40x_wrapper. It keeps a bit-accurate shadow copy of the CSR from retired writes and flags any retired read whose known bits disagree with the shadow. It provides assertion/cover hooks (fail pulse, sticky, counters) for the formal and simulation environments.

---
 rtl/uvmt_cv32e40x_rvfi_csr_shadow.sv | 119 +++++++++++
 tb/tb_uvmt_cv32e40x_rvfi_csr_shadow.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uvmt_cv32e40x_rvfi_csr_shadow.sv
// Shadow model of one CSR, built from the RVFI retirement channel.
// A retired read whose known bits differ from the shadow is flagged.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_UNKNOWN | no shadow bit trusted yet, so no read can be checked
// ST_TRACK   | some bits known; reads are compared against the shadow
// ST_FAIL    | a mismatch has been seen; stays here until reset
module uvmt_cv32e40x_rvfi_csr_shadow #(
    parameter int unsigned          XLEN             = 32,
    parameter logic [XLEN-1:0]      RESET_VALUE      = '0,
    parameter logic [XLEN-1:0]      RESET_KNOWN_MASK = '0,
    parameter int unsigned          CNT_W            = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rvfi_valid_i,
    input  logic [XLEN-1:0]   rvfi_csr_rmask_i,
    input  logic [XLEN-1:0]   rvfi_csr_wmask_i,
    input  logic [XLEN-1:0]   rvfi_csr_rdata_i,
    input  logic [XLEN-1:0]   rvfi_csr_wdata_i,
    output logic [XLEN-1:0]   shadow_o,
    output logic [XLEN-1:0]   known_mask_o,
    output logic [1:0]        state_o,
    output logic              check_fail_o,
    output logic              fail_sticky_o,
    output logic [CNT_W-1:0]  fail_cnt_o,
    output logic [CNT_W-1:0]  write_cnt_o
);

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'b00,
        ST_TRACK   = 2'b01,
        ST_FAIL    = 2'b10
    } state_t;

    localparam state_t RESET_STATE = (RESET_KNOWN_MASK != '0) ? ST_TRACK : ST_UNKNOWN;

    state_t            state_q;
    logic [XLEN-1:0]   shadow_q;
    logic [XLEN-1:0]   known_q;
    logic              check_fail_q;
    logic              fail_sticky_q;
    logic [CNT_W-1:0]  fail_cnt_q;
    logic [CNT_W-1:0]  write_cnt_q;

    logic [XLEN-1:0]   cmp;
    logic [XLEN-1:0]   learn;
    logic [XLEN-1:0]   shadow_nxt;
    logic [XLEN-1:0]   known_nxt;
    logic              mismatch;
    logic              wr_any;

    // Compare against the pre-write shadow; unknown read bits are learned
    // instead of checked, and a same-cycle write to a bit takes priority.
    always_comb begin
        cmp        = rvfi_csr_rmask_i & known_q;
        mismatch   = |((rvfi_csr_rdata_i ^ shadow_q) & cmp);
        learn      = rvfi_csr_rmask_i & ~known_q & ~rvfi_csr_wmask_i;
        shadow_nxt = (shadow_q & ~rvfi_csr_wmask_i & ~learn)
                   | (rvfi_csr_wdata_i & rvfi_csr_wmask_i)
                   | (rvfi_csr_rdata_i & learn);
        known_nxt  = known_q | rvfi_csr_wmask_i | learn;
        wr_any     = |rvfi_csr_wmask_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= RESET_STATE;
            shadow_q      <= RESET_VALUE & RESET_KNOWN_MASK;
            known_q       <= RESET_KNOWN_MASK;
            check_fail_q  <= 1'b0;
            fail_sticky_q <= 1'b0;
            fail_cnt_q    <= '0;
            write_cnt_q   <= '0;
        end else begin
            check_fail_q <= 1'b0;
            if (rvfi_valid_i) begin
                shadow_q     <= shadow_nxt;
                known_q      <= known_nxt;
                check_fail_q <= mismatch;
                if (mismatch) begin
                    fail_sticky_q <= 1'b1;
                    if (fail_cnt_q != '1) begin
                        fail_cnt_q <= fail_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                if (wr_any && (write_cnt_q != '1)) begin
                    write_cnt_q <= write_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                case (state_q)
                    ST_UNKNOWN: begin
                        if (mismatch) begin
                            state_q <= ST_FAIL;
                        end else if (known_nxt != '0) begin
                            state_q <= ST_TRACK;
                        end
                    end
                    ST_TRACK: begin
                        if (mismatch) begin
                            state_q <= ST_FAIL;
                        end
                    end
                    ST_FAIL: state_q <= ST_FAIL;
                    default: state_q <= ST_FAIL;
                endcase
            end
        end
    end

    assign shadow_o      = shadow_q;
    assign known_mask_o  = known_q;
    assign state_o       = state_q;
    assign check_fail_o  = check_fail_q;
    assign fail_sticky_o = fail_sticky_q;
    assign fail_cnt_o    = fail_cnt_q;
    assign write_cnt_o   = write_cnt_q;

endmodule

// File: tb/tb_uvmt_cv32e40x_rvfi_csr_shadow.sv
// Directed bench: three shadow instances with different reset/counter
// parameters share the data/mask bus, each with its own valid and reset.
module tb_uvmt_cv32e40x_rvfi_csr_shadow;

    logic        clk = 1'b0;
    logic        rst0, rst1, rst2;
    logic        v0, v1, v2;
    logic [31:0] rmask, wmask, rdata, wdata;

    logic [31:0] sh0, km0, sh1, km1, sh2, km2;
    logic [1:0]  st0, st1, st2;
    logic        cf0, cf1, cf2, sk0, sk1, sk2;
    logic [7:0]  fc0, wc0, fc2, wc2;
    logic [1:0]  fc1, wc1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uvmt_cv32e40x_rvfi_csr_shadow u0 (
        .clk_i(clk), .rst_ni(rst0), .rvfi_valid_i(v0),
        .rvfi_csr_rmask_i(rmask), .rvfi_csr_wmask_i(wmask),
        .rvfi_csr_rdata_i(rdata), .rvfi_csr_wdata_i(wdata),
        .shadow_o(sh0), .known_mask_o(km0), .state_o(st0),
        .check_fail_o(cf0), .fail_sticky_o(sk0),
        .fail_cnt_o(fc0), .write_cnt_o(wc0));

    uvmt_cv32e40x_rvfi_csr_shadow #(.CNT_W(2)) u1 (
        .clk_i(clk), .rst_ni(rst1), .rvfi_valid_i(v1),
        .rvfi_csr_rmask_i(rmask), .rvfi_csr_wmask_i(wmask),
        .rvfi_csr_rdata_i(rdata), .rvfi_csr_wdata_i(wdata),
        .shadow_o(sh1), .known_mask_o(km1), .state_o(st1),
        .check_fail_o(cf1), .fail_sticky_o(sk1),
        .fail_cnt_o(fc1), .write_cnt_o(wc1));

    uvmt_cv32e40x_rvfi_csr_shadow #(.RESET_VALUE(32'h8), .RESET_KNOWN_MASK(32'h8)) u2 (
        .clk_i(clk), .rst_ni(rst2), .rvfi_valid_i(v2),
        .rvfi_csr_rmask_i(rmask), .rvfi_csr_wmask_i(wmask),
        .rvfi_csr_rdata_i(rdata), .rvfi_csr_wdata_i(wdata),
        .shadow_o(sh2), .known_mask_o(km2), .state_o(st2),
        .check_fail_o(cf2), .fail_sticky_o(sk2),
        .fail_cnt_o(fc2), .write_cnt_o(wc2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] rm, input logic [31:0] wm,
                         input logic [31:0] rd, input logic [31:0] wd);
        rmask = rm; wmask = wm; rdata = rd; wdata = wd;
    endtask

    // One retirement on the selected instance; returns #1 after the capturing edge.
    task automatic retire(input int which, input logic [31:0] rm, input logic [31:0] wm,
                          input logic [31:0] rd, input logic [31:0] wd);
        @(negedge clk);
        drive(rm, wm, rd, wd);
        v0 = (which == 0); v1 = (which == 1); v2 = (which == 2);
        @(posedge clk);
        #1;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    endtask

    initial begin
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        @(posedge clk); #1;

        // Instance 0: nothing known after reset
        chk("u0_rst_state",  {30'd0, st0}, 32'h0);
        chk("u0_rst_known",  km0, 32'h0);
        chk("u0_rst_shadow", sh0, 32'h0);
        chk("u0_rst_fail",   {31'd0, cf0}, 32'h0);
        chk("u0_rst_wcnt",   {24'd0, wc0}, 32'h0);

        retire(0, 32'hFFFF_FFFF, 32'h0, 32'hDEAD_BEEF, 32'h0);
        chk("u0_learn_fail",   {31'd0, cf0}, 32'h0);
        chk("u0_learn_shadow", sh0, 32'hDEAD_BEEF);
        chk("u0_learn_known",  km0, 32'hFFFF_FFFF);
        chk("u0_learn_state",  {30'd0, st0}, 32'h1);

        retire(0, 32'h0, 32'h0000_FFFF, 32'h0, 32'h1234_5678);
        chk("u0_wr_shadow", sh0, 32'hDEAD_5678);
        chk("u0_wr_wcnt",   {24'd0, wc0}, 32'h1);

        retire(0, 32'hFFFF_FFFF, 32'h0, 32'hDEAD_5678, 32'h0);
        chk("u0_rd_ok_fail", {31'd0, cf0}, 32'h0);

        retire(0, 32'hFFFF_FFFF, 32'h0, 32'hDEAD_5679, 32'h0);
        chk("u0_mm_pulse",  {31'd0, cf0}, 32'h1);
        chk("u0_mm_sticky", {31'd0, sk0}, 32'h1);
        chk("u0_mm_state",  {30'd0, st0}, 32'h2);
        chk("u0_mm_fcnt",   {24'd0, fc0}, 32'h1);
        @(posedge clk); #1;
        chk("u0_mm_pulse_end", {31'd0, cf0}, 32'h0);

        retire(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hDEAD_5678, 32'hA5A5_A5A5);
        chk("u0_rw_fail",   {31'd0, cf0}, 32'h0);
        chk("u0_rw_shadow", sh0, 32'hA5A5_A5A5);
        chk("u0_rw_wcnt",   {24'd0, wc0}, 32'h2);
        chk("u0_rw_fcnt",   {24'd0, fc0}, 32'h1);
        chk("u0_rw_state",  {30'd0, st0}, 32'h2);

        // Valid low: mismatching data and a nonzero wmask must be ignored
        @(negedge clk);
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("u0_idle_fail", {31'd0, cf0}, 32'h0);
        end
        chk("u0_idle_shadow", sh0, 32'hA5A5_A5A5);
        chk("u0_idle_wcnt",   {24'd0, wc0}, 32'h2);
        chk("u0_idle_fcnt",   {24'd0, fc0}, 32'h1);

        // Instance 1: 2-bit counters saturate
        retire(1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
        chk("u1_learn_state", {30'd0, st1}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0);
            v1 = 1'b1;
            @(posedge clk); #1;
            chk("u1_mm_pulse", {31'd0, cf1}, 32'h1);
            chk("u1_mm_fcnt",  {30'd0, fc1}, (i < 3) ? i + 1 : 3);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(32'h0, 32'h1, 32'h0, 32'h1);
            v1 = 1'b1;
            @(posedge clk); #1;
            chk("u1_wr_wcnt", {30'd0, wc1}, (i < 3) ? i + 1 : 3);
        end
        v1 = 1'b0;
        chk("u1_wr_pulse_low", {31'd0, cf1}, 32'h0);
        chk("u1_fcnt_hold",    {30'd0, fc1}, 32'h3);

        // Instance 2: bit 3 known as 1 from reset
        chk("u2_rst_state",  {30'd0, st2}, 32'h1);
        chk("u2_rst_known",  km2, 32'h8);
        chk("u2_rst_shadow", sh2, 32'h8);
        retire(2, 32'h8, 32'h0, 32'h0, 32'h0);
        chk("u2_mm_pulse", {31'd0, cf2}, 32'h1);
        chk("u2_mm_state", {30'd0, st2}, 32'h2);
        #2 rst2 = 1'b0;
        #1;
        chk("u2_arst_sticky", {31'd0, sk2}, 32'h0);
        chk("u2_arst_state",  {30'd0, st2}, 32'h1);
        chk("u2_arst_pulse",  {31'd0, cf2}, 32'h0);
        chk("u2_arst_fcnt",   {24'd0, fc2}, 32'h0);
        @(negedge clk);
        rst2 = 1'b1;

        // Learn on read with a same-cycle write: written bit takes wdata
        retire(2, 32'hF0, 32'h10, 32'hF0, 32'h0);
        chk("u2_lw_fail",   {31'd0, cf2}, 32'h0);
        chk("u2_lw_shadow", sh2, 32'hE8);
        chk("u2_lw_known",  km2, 32'hF8);
        chk("u2_lw_wcnt",   {24'd0, wc2}, 32'h1);

        // Valid retirement with empty masks changes nothing
        retire(2, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("u2_nop_shadow", sh2, 32'hE8);
        chk("u2_nop_wcnt",   {24'd0, wc2}, 32'h1);
        chk("u2_nop_fail",   {31'd0, cf2}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
